// File: rtl/preg_free_list.sv
// preg_free_list: physical-register free list for rename.
// Circular array with a speculative head, a committed head and a tail. The
// pointers carry an extra wrap bit. A flush rewinds the speculative head to
// the committed head.
// Optional duplicate-release filter: define FREE_LIST_DUP_CHECK_EN.
module preg_free_list #(
  parameter int unsigned NUM_PREGS    = 128,
  parameter int unsigned NUM_AREGS    = 32,
  parameter int unsigned RENAME_WIDTH = 2,
  parameter int unsigned RETIRE_WIDTH = 4,
  localparam int unsigned PW          = $clog2(NUM_PREGS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [RENAME_WIDTH-1:0]            alloc_req,
  output logic                               alloc_gnt,
  output logic [RENAME_WIDTH-1:0][PW-1:0]    alloc_preg,
  input  logic [RETIRE_WIDTH-1:0]            free_valid,
  input  logic [RETIRE_WIDTH-1:0][PW-1:0]    free_preg,
  input  logic                               flush,
  output logic [PW:0]                        free_count,
  output logic                               empty,
  output logic                               err_dup_free
);

  typedef logic [PW:0]   ptr_t;
  typedef logic [PW-1:0] idx_t;

  idx_t entry_q [NUM_PREGS];
  ptr_t spec_head_q, spec_head_d;
  ptr_t commit_head_q, commit_head_d;
  ptr_t tail_q, tail_d;
  ptr_t n_alloc, n_rel;
  ptr_t alloc_k, rel_m;
  logic [RETIRE_WIDTH-1:0] rel_acc;
  idx_t rel_idx [RETIRE_WIDTH];

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PREGS-1:0] in_list_q, in_list_d, seen;
  logic                 dup_hit, err_q;
  ptr_t                 roll_len;
  idx_t                 roll_off;
`endif

  assign free_count = tail_q - spec_head_q;
  assign empty      = (free_count == '0);

  // Compact requesting lanes onto consecutive entries; grant all-or-nothing.
  always_comb begin
    alloc_k    = '0;
    alloc_preg = '0;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      alloc_preg[i] = entry_q[spec_head_q[PW-1:0] + alloc_k[PW-1:0]];
      if (alloc_req[i]) alloc_k = alloc_k + ptr_t'(1);
    end
    n_alloc   = alloc_k;
    alloc_gnt = (n_alloc <= free_count) && !flush && !rst;
  end

  // Compact accepted releases onto consecutive slots at the tail.
  always_comb begin
    rel_m   = '0;
    rel_acc = '0;
`ifdef FREE_LIST_DUP_CHECK_EN
    seen    = in_list_q;
    dup_hit = 1'b0;
`endif
    for (int unsigned j = 0; j < RETIRE_WIDTH; j++) begin
      rel_idx[j] = tail_q[PW-1:0] + rel_m[PW-1:0];
`ifdef FREE_LIST_DUP_CHECK_EN
      // A preg already free, or released by an earlier lane this cycle, is dropped.
      if (free_valid[j]) begin
        if (seen[free_preg[j]]) begin
          dup_hit = 1'b1;
        end else begin
          rel_acc[j]          = 1'b1;
          seen[free_preg[j]]  = 1'b1;
        end
      end
`else
      rel_acc[j] = free_valid[j];
`endif
      if (rel_acc[j]) rel_m = rel_m + ptr_t'(1);
    end
    n_rel = rel_m;
  end

  // Next pointers: flush rewinds to the post-release committed head.
  always_comb begin
    tail_d        = tail_q + n_rel;
    commit_head_d = commit_head_q + n_rel;
    if (flush)          spec_head_d = commit_head_d;
    else if (alloc_gnt) spec_head_d = spec_head_q + n_alloc;
    else                spec_head_d = spec_head_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= ptr_t'(NUM_PREGS - NUM_AREGS);
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

  // Entry storage: preloaded with the unmapped pregs, written by releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++)
        entry_q[i] <= (i < NUM_PREGS - NUM_AREGS) ? idx_t'(NUM_AREGS + i) : '0;
    end else begin
      for (int unsigned j = 0; j < RETIRE_WIDTH; j++)
        if (rel_acc[j]) entry_q[rel_idx[j]] <= free_preg[j];
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  // Membership of each preg in the free region [spec_head, tail).
  always_comb begin
    in_list_d = seen;
    roll_len  = spec_head_q - commit_head_d;
    roll_off  = '0;
    if (alloc_gnt) begin
      for (int unsigned i = 0; i < RENAME_WIDTH; i++)
        if (alloc_req[i]) in_list_d[alloc_preg[i]] = 1'b0;
    end
    // Rolled-back window runs from the new committed head to the old spec head.
    if (flush) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        roll_off = idx_t'(i) - commit_head_d[PW-1:0];
        if ({1'b0, roll_off} < roll_len) in_list_d[entry_q[i]] = 1'b1;
      end
    end
  end

  // Membership vector and sticky duplicate-release flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++)
        in_list_q[i] <= (i >= NUM_AREGS);
      err_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      err_q     <= err_q | dup_hit;
    end
  end

  assign err_dup_free = err_q;
`else
  assign err_dup_free = 1'b0;
`endif

endmodule
